// File: rtl/ahb_lite_arbiter_if.sv
// Bus bundle for ahb_lite_arbiter: flattened per-master request side plus the shared slave side.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface ahb_lite_arbiter_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [NM*AW-1:0] M_HADDR;
  logic [NM*2-1:0]  M_HTRANS;
  logic [NM-1:0]    M_HWRITE;
  logic [NM*3-1:0]  M_HSIZE;
  logic [NM*DW-1:0] M_HWDATA;
  logic [NM-1:0]    M_HLOCK;
  logic [NM-1:0]    M_HREADY;
  logic [DW-1:0]    M_HRDATA;

  logic [AW-1:0]    S_HADDR;
  logic [1:0]       S_HTRANS;
  logic             S_HWRITE;
  logic [2:0]       S_HSIZE;
  logic [DW-1:0]    S_HWDATA;
  logic             S_HMASTLOCK;
  logic [2:0]       S_HMASTER;
  logic             S_HREADY;
  logic [DW-1:0]    S_HRDATA;

  modport slave (
    input  M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, M_HLOCK, S_HREADY, S_HRDATA,
    output M_HREADY, M_HRDATA, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA, S_HMASTLOCK,
           S_HMASTER
  );

  modport master (
    output M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, M_HLOCK, S_HREADY, S_HRDATA,
    input  M_HREADY, M_HRDATA, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA, S_HMASTLOCK,
           S_HMASTER
  );
endinterface

// File: rtl/ahb_lite_arbiter.sv
// AHB-lite N-master to one-slave arbiter: fixed-priority or round-robin address-phase ownership,
// bursts and locked sequences are never split, data phase follows the previous owner.
module ahb_lite_arbiter #(
  parameter int unsigned NM       = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned ARB_MODE = 1
) (
  input logic                HCLK,
  input logic                HRESET,
  ahb_lite_arbiter_if.slave  bus
);
  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  logic [2:0]    aown_q, aown_d;
  logic [2:0]    down_q, down_d;
  logic          dact_q, dact_d;
  logic [NM-1:0] req;
  logic [2:0]    winner;
  logic          found;
  logic          arb_point;
  int            tgt;

  always_comb begin
    req = '0;
    for (int i = 0; i < int'(NM); i++) req[i] = bus.M_HTRANS[2*i+1];
  end

  // Address-phase mux follows aown, write data follows the data-phase owner.
  always_comb begin
    bus.S_HADDR     = '0;
    bus.S_HTRANS    = HtransIdle;
    bus.S_HWRITE    = 1'b0;
    bus.S_HSIZE     = '0;
    bus.S_HMASTLOCK = 1'b0;
    bus.S_HWDATA    = '0;
    for (int i = 0; i < int'(NM); i++) begin
      if (aown_q == 3'(i)) begin
        bus.S_HADDR     = bus.M_HADDR[i*AW +: AW];
        bus.S_HTRANS    = bus.M_HTRANS[2*i +: 2];
        bus.S_HWRITE    = bus.M_HWRITE[i];
        bus.S_HSIZE     = bus.M_HSIZE[3*i +: 3];
        bus.S_HMASTLOCK = bus.M_HLOCK[i];
      end
      if (down_q == 3'(i)) bus.S_HWDATA = bus.M_HWDATA[i*DW +: DW];
    end
  end

  assign bus.S_HMASTER = aown_q;
  assign bus.M_HRDATA  = bus.S_HRDATA;

  // Non-owners that request are stalled so they hold their address until granted.
  always_comb begin
    bus.M_HREADY = '1;
    for (int i = 0; i < int'(NM); i++) begin
      if (aown_q == 3'(i) || (dact_q && down_q == 3'(i))) bus.M_HREADY[i] = bus.S_HREADY;
      else                                                 bus.M_HREADY[i] = ~req[i];
    end
  end

  always_comb begin
    winner = aown_q;
    found  = 1'b0;
    tgt    = 0;
    if (ARB_MODE == 0) begin
      for (int i = int'(NM) - 1; i >= 0; i--) begin
        if (req[i]) winner = 3'(i);
      end
    end else begin
      // Search starts just past the owner, so the owner is considered last.
      for (int k = 1; k <= int'(NM); k++) begin
        tgt = int'(aown_q) + k;
        if (tgt >= int'(NM)) tgt = tgt - int'(NM);
        for (int i = 0; i < int'(NM); i++) begin
          if (!found && req[i] && tgt == i) begin
            winner = 3'(i);
            found  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    aown_d    = aown_q;
    down_d    = down_q;
    dact_d    = dact_q;
    arb_point = (bus.S_HTRANS == HtransIdle || bus.S_HTRANS == HtransNonseq) &&
                !bus.S_HMASTLOCK;
    if (bus.S_HREADY) begin
      down_d = aown_q;
      dact_d = bus.S_HTRANS[1];
      if (arb_point && |req) aown_d = winner;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aown_q <= '0;
      down_q <= '0;
      dact_q <= 1'b0;
    end else begin
      aown_q <= aown_d;
      down_q <= down_d;
      dact_q <= dact_d;
    end
  end
endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Self-checking bench for ahb_lite_arbiter, three masters in round-robin mode.
module tb_ahb_lite_arbiter;
  localparam int unsigned NM = 3;
  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  ahb_lite_arbiter_if #(.NM(NM), .AW(32), .DW(32)) bus ();

  ahb_lite_arbiter #(.NM(NM), .AW(32), .DW(32), .ARB_MODE(1)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  mst;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic        lock;
    logic [2:0]  rdy;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, o;

  // Master i has fixed HWRITE (M1 reads) and HSIZE = 2 - i, so both follow the owner index.
  function automatic obs_t mk(int m, logic [31:0] a, logic [1:0] tr, logic [2:0] rdy, logic lk);
    obs_t r;
    r.mst = 3'(m); r.addr = a; r.trans = tr; r.wr = (m != 1); r.size = 3'(2 - m);
    r.lock = lk; r.rdy = rdy;
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t r;
    r.mst = bus.S_HMASTER; r.addr = bus.S_HADDR; r.trans = bus.S_HTRANS; r.wr = bus.S_HWRITE;
    r.size = bus.S_HSIZE; r.lock = bus.S_HMASTLOCK; r.rdy = bus.M_HREADY;
    return r;
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf("mst=%0d addr=%h tr=%0d wr=%b sz=%0d lk=%b rdy=%b",
                     x.mst, x.addr, x.trans, x.wr, x.size, x.lock, x.rdy);
  endfunction

  task automatic drive_m(int i, logic [1:0] tr, logic [31:0] a, logic lk);
    bus.M_HTRANS[2*i +: 2] = tr;
    bus.M_HADDR[32*i +: 32] = a;
    bus.M_HLOCK[i] = lk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.M_HTRANS = '0;
    bus.M_HADDR  = '0;
    bus.M_HLOCK  = '0;
    bus.S_HREADY = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive_m(0, IDL, 32'hA0, 1'b0);
    drive_m(1, NSQ, 32'h100, 1'b0);
    bus.S_HREADY = 1'b0;
    exp_q.push_back(mk(0, 32'hA0, IDL, 3'b100, 1'b0));
    @(negedge clk); o = observe(); e = exp_q.pop_front(); total++;
    if (o !== e) $display("FAIL reset_bus: got %s, want %s", fmt(o), fmt(e)); else passed++;
    total++;
    if ({dut.dact_q, dut.down_q} !== 4'b0) $display("FAIL reset_regs: got dact=%b down=%0d, want 0/0",
                                                    dut.dact_q, dut.down_q);
    else passed++;
    #1 bus.S_HREADY = 1'b1;
    exp_q.push_back(mk(0, 32'hA0, IDL, 3'b101, 1'b0));
    #1 o = observe(); e = exp_q.pop_front(); total++;
    if (o !== e) $display("FAIL reset_ready: got %s, want %s", fmt(o), fmt(e)); else passed++;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive_m(1, NSQ, 32'h100, 1'b0); exp_q.push_back(mk(0, 0, IDL, 3'b101, 0)); end
        1: exp_q.push_back(mk(1, 32'h100, NSQ, 3'b111, 0));
        default: begin drive_m(1, IDL, 0, 1'b0); exp_q.push_back(mk(1, 0, IDL, 3'b111, 0)); end
      endcase
      @(negedge clk); o = observe(); e = exp_q.pop_front(); total++;
      if (o !== e) $display("FAIL single c%0d: got %s, want %s", c, fmt(o), fmt(e)); else passed++;
      tick();
    end
  endtask

  task automatic test_round_robin();
    int m, p;
    do_reset();
    for (int i = 0; i < 3; i++) drive_m(i, NSQ, 32'h0C0 + 32'(i) * 32'h100, 1'b0);
    for (int c = 0; c < 6; c++) begin
      m = c % 3;
      p = (c + 2) % 3;
      exp_q.push_back(mk(m, 32'h0C0 + 32'(m) * 32'h100, NSQ,
                         (c == 0) ? 3'b001 : (3'(1 << m) | 3'(1 << p)), 1'b0));
      @(negedge clk); o = observe(); e = exp_q.pop_front(); total++;
      if (o !== e) $display("FAIL rr c%0d: got %s, want %s", c, fmt(o), fmt(e)); else passed++;
      tick();
    end
  endtask

  task automatic test_burst();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin drive_m(0, NSQ, 32'h40, 0); exp_q.push_back(mk(0, 32'h40, NSQ, 3'b111, 0)); end
        1: begin
          drive_m(0, SEQ, 32'h44, 0); drive_m(2, NSQ, 32'h200, 0);
          exp_q.push_back(mk(0, 32'h44, SEQ, 3'b011, 0));
        end
        2: begin drive_m(0, SEQ, 32'h48, 0); exp_q.push_back(mk(0, 32'h48, SEQ, 3'b011, 0)); end
        3: begin drive_m(0, SEQ, 32'h4C, 0); exp_q.push_back(mk(0, 32'h4C, SEQ, 3'b011, 0)); end
        4: begin drive_m(0, IDL, 0, 0); exp_q.push_back(mk(0, 0, IDL, 3'b011, 0)); end
        5: exp_q.push_back(mk(2, 32'h200, NSQ, 3'b111, 0));
        default: begin drive_m(2, IDL, 0, 0); exp_q.push_back(mk(2, 0, IDL, 3'b111, 0)); end
      endcase
      @(negedge clk); o = observe(); e = exp_q.pop_front(); total++;
      if (o !== e) $display("FAIL burst c%0d: got %s, want %s", c, fmt(o), fmt(e)); else passed++;
      tick();
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin drive_m(1, NSQ, 32'h100, 1); exp_q.push_back(mk(0, 0, IDL, 3'b101, 0)); end
        1: begin drive_m(0, NSQ, 32'h80, 0); exp_q.push_back(mk(1, 32'h100, NSQ, 3'b110, 1)); end
        2: begin drive_m(1, NSQ, 32'h104, 1); exp_q.push_back(mk(1, 32'h104, NSQ, 3'b110, 1)); end
        3: begin drive_m(1, NSQ, 32'h108, 1); exp_q.push_back(mk(1, 32'h108, NSQ, 3'b110, 1)); end
        4: begin drive_m(1, IDL, 0, 0); exp_q.push_back(mk(1, 0, IDL, 3'b110, 0)); end
        5: exp_q.push_back(mk(0, 32'h80, NSQ, 3'b111, 0));
        default: begin drive_m(0, IDL, 0, 0); exp_q.push_back(mk(0, 0, IDL, 3'b111, 0)); end
      endcase
      @(negedge clk); o = observe(); e = exp_q.pop_front(); total++;
      if (o !== e) $display("FAIL lock c%0d: got %s, want %s", c, fmt(o), fmt(e)); else passed++;
      tick();
    end
  endtask

  task automatic test_wait();
    logic [31:0] wd;
    do_reset();
    bus.S_HRDATA = 32'hCAFE_0001;
    bus.M_HWDATA[31:0] = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin
          drive_m(0, NSQ, 32'h300, 0); drive_m(1, NSQ, 32'h100, 0);
          exp_q.push_back(mk(0, 32'h300, NSQ, 3'b101, 0));
        end
        1: begin
          drive_m(0, NSQ, 32'h304, 0); bus.S_HREADY = 1'b0;
          exp_q.push_back(mk(1, 32'h100, NSQ, 3'b100, 0));
        end
        2: exp_q.push_back(mk(1, 32'h100, NSQ, 3'b100, 0));
        3: begin bus.S_HREADY = 1'b1; exp_q.push_back(mk(1, 32'h100, NSQ, 3'b111, 0)); end
        4: begin drive_m(1, IDL, 0, 0); exp_q.push_back(mk(0, 32'h304, NSQ, 3'b111, 0)); end
        default: begin drive_m(0, IDL, 0, 0); exp_q.push_back(mk(0, 0, IDL, 3'b111, 0)); end
      endcase
      @(negedge clk); o = observe(); e = exp_q.pop_front(); total++;
      if (o !== e) $display("FAIL wait c%0d: got %s, want %s", c, fmt(o), fmt(e)); else passed++;
      if (c >= 1 && c <= 4) begin
        wd = (c < 4) ? 32'hDEAD_BEEF : 32'h1111_1111;
        total++;
        if (bus.S_HWDATA !== wd) $display("FAIL wait_wdata c%0d: got %h, want %h", c,
                                          bus.S_HWDATA, wd);
        else passed++;
      end
      if (c == 2) begin
        total++;
        if (bus.M_HRDATA !== 32'hCAFE_0001) $display("FAIL rdata: got %h, want cafe0001",
                                                     bus.M_HRDATA);
        else passed++;
      end
      tick();
    end
    bus.M_HWDATA[31:0] = 32'h0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin drive_m(2, NSQ, 32'h200, 0); exp_q.push_back(mk(0, 0, IDL, 3'b011, 0)); end
        1: exp_q.push_back(mk(2, 32'h200, NSQ, 3'b111, 0));
        2: begin drive_m(2, SEQ, 32'h204, 0); exp_q.push_back(mk(2, 32'h204, SEQ, 3'b111, 0)); end
        3: begin
          drive_m(2, SEQ, 32'h208, 0); rst = 1'b1;
          exp_q.push_back(mk(2, 32'h208, SEQ, 3'b111, 0));
        end
        default: begin rst = 1'b0; drive_m(2, IDL, 0, 0); exp_q.push_back(mk(0, 0, IDL, 3'b111, 0)); end
      endcase
      @(negedge clk); o = observe(); e = exp_q.pop_front(); total++;
      if (o !== e) $display("FAIL rst_burst c%0d: got %s, want %s", c, fmt(o), fmt(e));
      else passed++;
      if (c == 4) begin
        total++;
        if (dut.dact_q !== 1'b0) $display("FAIL rst_burst_dact: got %b, want 0", dut.dact_q);
        else passed++;
      end
      tick();
    end
  endtask

  initial begin
    bus.M_HTRANS = '0;
    bus.M_HADDR  = '0;
    bus.M_HLOCK  = '0;
    bus.M_HWRITE = 3'b101;
    bus.M_HSIZE  = {3'd0, 3'd1, 3'd2};
    bus.M_HWDATA = {32'h2222_2222, 32'h1111_1111, 32'h0};
    bus.S_HREADY = 1'b1;
    bus.S_HRDATA = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_lock();
    test_wait();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule
